rfphoenix_fifo_unloader: RTL and testbench

- Downstream consumer of the core's small distributed-RAM FIFO, whose registered dout returns the popped entry one or more cycles after rd.
- Issues pop requests ahead of demand, absorbs read latency in a small credit-managed output buffer, and presents a valid/ready stream to the next pipeline stage.
- Sustains one transfer per cycle when the FIFO is non-empty and the sink is ready.

---
 rtl/rfphoenix_fifo_unloader.sv | 154 +++++++++++++++
 tb/tb_rfphoenix_fifo_unloader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rfphoenix_fifo_unloader.sv
`default_nettype none
// ============================================================================
// Module  : rfphoenix_fifo_unloader
// Purpose : Credit-based prefetching unloader for a registered-dout FIFO;
//           presents a valid/ready stream. Optional stats counters are built
//           when RFPHOENIX_UNLOADER_STATS_EN is defined.
// Revision: 1.0
// ============================================================================
module rfphoenix_fifo_unloader #(
  parameter int WID = 3,
  parameter int LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      fifo_empty,
  input  logic [WID-1:0]            fifo_dout,
  output logic                      fifo_rd,
  output logic                      o_v,
  output logic [WID-1:0]            o_data,
  input  logic                      o_rdy,
`ifdef RFPHOENIX_UNLOADER_STATS_EN
  output logic [31:0]               stall_cnt,
  output logic [31:0]               starve_cnt,
`endif
  output logic [$clog2(LAT+2)-1:0]  o_cnt
);

  localparam int BDEP = LAT + 1;
  localparam int CW   = $clog2(BDEP + 1);
  localparam int PW   = $clog2(BDEP);

  localparam logic [PW-1:0] PMAX   = PW'(BDEP - 1);
  localparam logic [CW-1:0] BDEP_C = CW'(BDEP);
  localparam logic [CW:0]   BDEP_W = (CW+1)'(BDEP);

  logic [PW-1:0]  wptr_q, wptr_d;
  logic [PW-1:0]  rptr_q, rptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [LAT-1:0] infl_q, infl_d;
  logic [LAT-1:0] w_infl_shift;
  logic [WID-1:0] mem_q [BDEP];

  logic           w_pop;
  logic           w_arrive;
  logic [CW-1:0]  w_pc;
  logic [CW:0]    w_used;

  function automatic logic [CW-1:0] popcnt(input logic [LAT-1:0] v);
    logic [CW-1:0] pc;
    pc = '0;
    for (int i = 0; i < LAT; i++) begin
      pc = pc + CW'(v[i]);
    end
    return pc;
  endfunction

  // Depth need not be a power of two, so wrap explicitly at the last slot.
  function automatic logic [PW-1:0] nxt_ptr(input logic [PW-1:0] p);
    return (p == PMAX) ? '0 : p + 1'b1;
  endfunction

  generate
    if (LAT == 1) begin : g_lat1
      assign w_infl_shift = fifo_rd;
    end else begin : g_latn
      assign w_infl_shift = {infl_q[LAT-2:0], fifo_rd};
    end
  endgenerate

  assign o_v      = (cnt_q != '0);
  assign o_data   = mem_q[rptr_q];
  assign o_cnt    = cnt_q;
  assign w_pop    = o_v & o_rdy;
  assign w_arrive = infl_q[LAT-1];
  assign w_pc     = popcnt(infl_q);

  // A slot freed by this cycle's handoff may be re-requested in the same cycle.
  assign w_used  = {1'b0, cnt_q} + {1'b0, w_pc} - {{CW{1'b0}}, w_pop};
  assign fifo_rd = ~rst & ~fifo_empty & ~flush & (w_used < BDEP_W);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    infl_d = w_infl_shift;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
      infl_d = '0;
    end else begin
      if (w_arrive) wptr_d = nxt_ptr(wptr_q);
      if (w_pop)    rptr_d = nxt_ptr(rptr_q);
      case ({w_arrive, w_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      infl_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      infl_q <= infl_d;
    end
  end

  // Data dropped during flush: those pops were consumed, not returned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BDEP; i++) begin
        mem_q[i] <= '0;
      end
    end else if (w_arrive && !flush) begin
      mem_q[wptr_q] <= fifo_dout;
    end
  end

`ifdef RFPHOENIX_UNLOADER_STATS_EN
  logic [31:0] stall_q;
  logic [31:0] starve_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q  <= '0;
      starve_q <= '0;
    end else begin
      if (o_v && !o_rdy && (stall_q != '1))
        stall_q <= stall_q + 1'b1;
      if (!o_v && o_rdy && fifo_empty && (starve_q != '1))
        starve_q <= starve_q + 1'b1;
    end
  end

  assign stall_cnt  = stall_q;
  assign starve_cnt = starve_q;
`endif

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_arrive && !flush && (cnt_q == BDEP_C)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_rfphoenix_fifo_unloader.sv
`default_nettype none
// Bench for rfphoenix_fifo_unloader: LAT=1 and LAT=2 instances, each fed by a
// small registered-dout FIFO model.
module tb_rfphoenix_fifo_unloader;

  logic clk = 1'b0;
  logic rst;
  logic flush1, flush2, rdy1, rdy2;
  logic e1, e2, fifo_rd1, fifo_rd2, o_v1, o_v2;
  logic [7:0] dout1, dout2, o_data1, o_data2;
  logic [1:0] o_cnt1, o_cnt2;
`ifdef RFPHOENIX_UNLOADER_STATS_EN
  logic [31:0] stall1, starve1, stall2, starve2;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mem1 [0:63];
  logic [7:0] mem2 [0:63];
  int h1 = 0, t1 = 0, h2 = 0, t2 = 0;
  logic [7:0] p1 = 8'h00, q0 = 8'h00, q1 = 8'h00;

  always #5 clk = ~clk;

  rfphoenix_fifo_unloader #(.WID(8), .LAT(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush1), .fifo_empty(e1), .fifo_dout(dout1),
    .fifo_rd(fifo_rd1), .o_v(o_v1), .o_data(o_data1), .o_rdy(rdy1),
`ifdef RFPHOENIX_UNLOADER_STATS_EN
    .stall_cnt(stall1), .starve_cnt(starve1),
`endif
    .o_cnt(o_cnt1)
  );

  rfphoenix_fifo_unloader #(.WID(8), .LAT(2)) dut2 (
    .clk(clk), .rst(rst), .flush(flush2), .fifo_empty(e2), .fifo_dout(dout2),
    .fifo_rd(fifo_rd2), .o_v(o_v2), .o_data(o_data2), .o_rdy(rdy2),
`ifdef RFPHOENIX_UNLOADER_STATS_EN
    .stall_cnt(stall2), .starve_cnt(starve2),
`endif
    .o_cnt(o_cnt2)
  );

  // FIFO models: pointer-based, registered dout with latency 1 and 2.
  assign e1 = (h1 == t1);
  assign e2 = (h2 == t2);
  assign dout1 = p1;
  assign dout2 = q1;

  always @(posedge clk) begin
    if (fifo_rd1 && (h1 != t1)) begin
      p1 <= mem1[h1];
      h1 <= h1 + 1;
    end
    if (fifo_rd2 && (h2 != t2)) begin
      q0 <= mem2[h2];
      h2 <= h2 + 1;
    end
    q1 <= q0;
  end

  typedef struct packed {
    logic       rdy;
    logic       rd;
    logic       v;
    logic [7:0] data;
    logic [1:0] cnt;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push1(input logic [7:0] v);
    mem1[t1] = v;
    t1 = t1 + 1;
  endtask

  task automatic push2(input logic [7:0] v);
    mem2[t2] = v;
    t2 = t2 + 1;
  endtask

  // Collect n handshakes from one instance, expecting base, base+step, ...
  task automatic collect(input int which, input int n, input logic [7:0] base,
                         input logic [7:0] step, input bit toggle, input string nm);
    int k;
    bit over;
    logic v, r;
    logic [7:0] d;
    logic [7:0] exp;
    k = 0;
    over = 1'b0;
    for (int c = 0; c < 80 && k < n; c++) begin
      @(negedge clk);
      r = toggle ? ((c % 2) == 0) : 1'b1;
      if (which == 1) rdy1 = r; else rdy2 = r;
      #1;
      v = (which == 1) ? o_v1 : o_v2;
      d = (which == 1) ? o_data1 : o_data2;
      if ((which == 2) && (o_cnt2 > 2'd3)) over = 1'b1;
      if (v && r) begin
        exp = base + 8'(k) * step;
        chk($sformatf("%s item%0d", nm, k), {24'h0, d}, {24'h0, exp});
        k++;
      end
    end
    chk($sformatf("%s delivered", nm), k, n);
    if (which == 2) chk($sformatf("%s cnt_bound", nm), {31'h0, over}, 32'h0);
  endtask

  initial begin
    // {rdy, fifo_rd, o_v, o_data, o_cnt} per cycle.
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 2'd0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 8'h00, 2'd0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 8'h11, 2'd1};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 8'h22, 2'd1};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 8'h33, 2'd1};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 8'h00, 2'd0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 8'h11, 2'd1};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 8'h11, 2'd2};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 8'h11, 2'd2};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 8'h11, 2'd2};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 8'h22, 2'd1};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 8'h33, 2'd1};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 8'h44, 2'd1};
    tbl[15] = '{1'b1, 1'b0, 1'b1, 8'h55, 2'd1};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 8'h00, 2'd0};

    rst = 1'b1; flush1 = 1'b0; flush2 = 1'b0; rdy1 = 1'b0; rdy2 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst o_v1",    {31'h0, o_v1},     32'h0);
    chk("rst o_cnt1",  {30'h0, o_cnt1},   32'h0);
    chk("rst o_data1", {24'h0, o_data1},  32'h0);
    chk("rst fifo_rd1",{31'h0, fifo_rd1}, 32'h0);
    chk("rst o_v2",    {31'h0, o_v2},     32'h0);
    chk("rst o_cnt2",  {30'h0, o_cnt2},   32'h0);
    rst = 1'b0;

    // LAT=1 cycle-exact streaming and back-pressure.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i == 0) begin
        push1(8'h11); push1(8'h22); push1(8'h33);
      end
      if (i == 6) begin
        push1(8'h11); push1(8'h22); push1(8'h33); push1(8'h44); push1(8'h55);
      end
      rdy1 = tbl[i].rdy;
      #1;
      chk($sformatf("vec%0d fifo_rd", i), {31'h0, fifo_rd1}, {31'h0, tbl[i].rd});
      chk($sformatf("vec%0d o_v", i),     {31'h0, o_v1},     {31'h0, tbl[i].v});
      chk($sformatf("vec%0d o_cnt", i),   {30'h0, o_cnt1},   {30'h0, tbl[i].cnt});
      if (tbl[i].v)
        chk($sformatf("vec%0d o_data", i), {24'h0, o_data1}, {24'h0, tbl[i].data});
    end

    // LAT=2 with toggling ready: 8 entries in order.
    @(negedge clk);
    for (int i = 0; i < 8; i++) push2(8'hA0 + 8'(i));
    collect(2, 8, 8'hA0, 8'h01, 1'b1, "toggle");

    // LAT=2 flush with two buffered and one in flight.
    @(negedge clk);
    rdy2 = 1'b0;
    flush2 = 1'b1;
    @(negedge clk);
    flush2 = 1'b0;
    push2(8'h11); push2(8'h22); push2(8'h33); push2(8'h44); push2(8'h55);
    repeat (4) @(negedge clk);
    chk("pre-flush o_cnt", {30'h0, o_cnt2}, 32'd2);
    flush2 = 1'b1;
    @(negedge clk);
    chk("flush o_v",     {31'h0, o_v2},     32'h0);
    chk("flush o_cnt",   {30'h0, o_cnt2},   32'h0);
    chk("flush fifo_rd", {31'h0, fifo_rd2}, 32'h0);
    flush2 = 1'b0;
    #1;
    chk("post-flush fifo_rd", {31'h0, fifo_rd2}, 32'h1);
    collect(2, 2, 8'h44, 8'h11, 1'b0, "after_flush");

    // LAT=1 asynchronous reset mid-stream.
    @(negedge clk);
    rdy2 = 1'b0;
    rdy1 = 1'b1;
    for (int i = 1; i <= 6; i++) push1(8'(i));
    repeat (3) @(posedge clk);
    #2;
    chk("pre-rst o_data", {24'h0, o_data1}, 32'h02);
    rst = 1'b1;
    #1;
    chk("arst o_v",     {31'h0, o_v1},     32'h0);
    chk("arst o_cnt",   {30'h0, o_cnt1},   32'h0);
    chk("arst fifo_rd", {31'h0, fifo_rd1}, 32'h0);
    chk("arst o_data",  {24'h0, o_data1},  32'h0);
    @(negedge clk);
    rst = 1'b0;
    collect(1, 3, 8'h04, 8'h01, 1'b0, "after_rst");

`ifdef RFPHOENIX_UNLOADER_STATS_EN
    @(negedge clk);
    rst = 1'b1;
    rdy1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("stats clr stall",  stall1,  32'd0);
    chk("stats clr starve", starve1, 32'd0);
    push1(8'h77);
    begin : wait_v
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        #1;
        if (o_v1) disable wait_v;
      end
      chk("stats wait o_v", {31'h0, o_v1}, 32'h1);
    end
    repeat (4) @(negedge clk);
    rdy1 = 1'b1;
    @(negedge clk);
    repeat (3) @(negedge clk);
    rdy1 = 1'b0;
    chk("stall_cnt",  stall1,  32'd4);
    chk("starve_cnt", starve1, 32'd3);
    flush1 = 1'b1;
    @(negedge clk);
    flush1 = 1'b0;
    chk("flush stall_cnt",  stall1,  32'd4);
    chk("flush starve_cnt", starve1, 32'd3);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
